// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: datapath widths, ALU
// function codes and the forwarding-source select encoding.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int FUN_W  = 6;

    // ALU function codes driven on ALUFun.
    localparam logic [FUN_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [FUN_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [FUN_W-1:0] ALU_AND = 6'b011000;
    localparam logic [FUN_W-1:0] ALU_OR  = 6'b011110;
    localparam logic [FUN_W-1:0] ALU_XOR = 6'b010110;
    localparam logic [FUN_W-1:0] ALU_NOR = 6'b010001;
    localparam logic [FUN_W-1:0] ALU_A   = 6'b011010;
    localparam logic [FUN_W-1:0] ALU_SLL = 6'b100000;
    localparam logic [FUN_W-1:0] ALU_SRL = 6'b100001;
    localparam logic [FUN_W-1:0] ALU_SRA = 6'b100011;

    // Compare operations share the 11xxx1 pattern.
    function automatic logic is_compare_fun(input logic [FUN_W-1:0] fun);
        return (fun[5:4] == 2'b11) && fun[0];
    endfunction

    // Which pipeline stage supplies a source operand.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/alu_fwd_mux.sv
// Forwarding mux for one source register: picks the youngest in-flight
// writer of that register, falling back to the latched register-file value.
module alu_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic [DATA_W-1:0] src_data_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic [DATA_W-1:0] fwd_data_o
);
    import alu_pkg::*;

    fwd_sel_e sel;

    // Priority select: EX/MEM is younger than MEM/WB so it wins; r0 is never forwarded.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel = FWD_NONE;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr_i)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_addr_i)) begin
            sel = FWD_MEMWB;
        end
    end

    // Steer the selected source onto the output.
    always_comb begin
        fwd_data_o = src_data_i;
        case (sel)
            FWD_EXMEM: fwd_data_o = exmem_result_i;
            FWD_MEMWB: fwd_data_o = memwb_result_i;
            default:   fwd_data_o = src_data_i;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding. Drives the ALU
// A/B/ALUFun inputs and flags load-use hazards for the hazard unit.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FUN_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_dst,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_ALUSrc1,
    input  logic              id_ALUSrc2,
    input  logic [FUN_W-1:0]  id_ALUFun,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              exmem_RegWrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_RegWrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [FUN_W-1:0]  ALUFun,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              load_use_hazard
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              alusrc1;
        logic              alusrc2;
        logic [FUN_W-1:0]  alufun;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
    } stage_t;

    stage_t            stage_q;
    stage_t            stage_d;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    alu_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_addr_i       (stage_q.rs_addr),
        .src_data_i       (stage_q.rs_data),
        .exmem_regwrite_i (exmem_RegWrite),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_regwrite_i (memwb_RegWrite),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .fwd_data_o       (fwd_rs)
    );

    alu_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_addr_i       (stage_q.rt_addr),
        .src_data_i       (stage_q.rt_data),
        .exmem_regwrite_i (exmem_RegWrite),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_regwrite_i (memwb_RegWrite),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .fwd_data_o       (fwd_rt)
    );

    // Next-state: flush loads a bubble, stall holds control but captures forwarded data, else load ID.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            // A value forwarded now must survive its producer retiring during the stall.
            stage_d.rs_data = fwd_rs;
            stage_d.rt_data = fwd_rt;
        end else begin
            stage_d.valid    = id_valid;
            stage_d.regwrite = id_RegWrite;
            stage_d.memread  = id_MemRead;
            stage_d.memwrite = id_MemWrite;
            stage_d.alusrc1  = id_ALUSrc1;
            stage_d.alusrc2  = id_ALUSrc2;
            stage_d.alufun   = id_ALUFun;
            stage_d.rs_addr  = id_rs_addr;
            stage_d.rt_addr  = id_rt_addr;
            stage_d.rd       = id_rd_dst;
            stage_d.rs_data  = id_rs_data;
            stage_d.rt_data  = id_rt_data;
            stage_d.imm      = id_imm;
            stage_d.shamt    = id_shamt;
        end
    end

    // Stage register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Operand muxes toward the ALU; shamt is zero-extended, never sign-extended.
    always_comb begin
        A = stage_q.alusrc1 ? {{(DATA_W-5){1'b0}}, stage_q.shamt} : fwd_rs;
        B = stage_q.alusrc2 ? stage_q.imm : fwd_rt;
    end

    // Registered control out, plus the conservative load-use check against the ID operands.
    always_comb begin
        ALUFun          = stage_q.alufun;
        ex_valid        = stage_q.valid;
        ex_RegWrite     = stage_q.regwrite;
        ex_MemRead      = stage_q.memread;
        ex_MemWrite     = stage_q.memwrite;
        ex_rd           = stage_q.rd;
        ex_store_data   = fwd_rt;
        load_use_hazard = stage_q.valid && stage_q.memread && (stage_q.rd != '0) &&
                          ((stage_q.rd == id_rs_addr) || (stage_q.rd == id_rt_addr));
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, load, forwarding priority,
// load-use detection, stall refresh, flush-over-stall and immediate/store paths.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_dst;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_ALUSrc1, id_ALUSrc2;
    logic [5:0]  id_ALUFun;
    logic        id_RegWrite, id_MemRead, id_MemWrite;
    logic        exmem_RegWrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_RegWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] A, B;
    logic [5:0]  ALUFun;
    logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;
    logic        load_use_hazard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rd_dst(id_rd_dst), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_ALUSrc1(id_ALUSrc1),
        .id_ALUSrc2(id_ALUSrc2), .id_ALUFun(id_ALUFun), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .A(A), .B(B), .ALUFun(ALUFun), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
    );

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_dst = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
        id_ALUSrc1 = 0; id_ALUSrc2 = 0; id_ALUFun = 0;
        id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0;
        exmem_RegWrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_RegWrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic test_reset();
        id_valid = 1; id_rs_addr = 3; id_rt_addr = 4; id_rd_dst = 9;
        id_rs_data = 32'hAAAA_0001; id_rt_data = 32'hBBBB_0002; id_imm = 32'h77;
        id_ALUFun = ALU_AND; id_RegWrite = 1; id_MemRead = 1;
        exmem_RegWrite = 1; exmem_rd = 5; exmem_result = 32'hCAFE_0005;
        reset = 1;
        step();
        checks++; if (A !== 32'h0) begin errors++; $display("FAIL reset_A got %h want %h", A, 32'h0); end
        checks++; if (B !== 32'h0) begin errors++; $display("FAIL reset_B got %h want %h", B, 32'h0); end
        checks++; if (ALUFun !== 6'b000000) begin errors++; $display("FAIL reset_ALUFun got %b want %b", ALUFun, 6'b000000); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
        checks++; if ({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rd} !== 8'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rd}); end
        checks++; if (load_use_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", load_use_hazard); end
        // r0 writers must not leak into the cleared stage.
        exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
        memwb_RegWrite = 1; memwb_rd = 0; memwb_result = 32'hEEEE_EEEE;
        #1;
        checks++; if (A !== 32'h0 || B !== 32'h0) begin errors++; $display("FAIL reset_r0_fwd got A=%h B=%h want 0", A, B); end
        reset = 0;
        clear_inputs();
    endtask

    task automatic test_load();
        id_valid = 1; id_rs_addr = 3; id_rt_addr = 4; id_rd_dst = 8;
        id_rs_data = 32'h5; id_rt_data = 32'h3; id_ALUFun = ALU_AND; id_RegWrite = 1;
        step();
        checks++; if (A !== 32'h5) begin errors++; $display("FAIL load_A got %h want %h", A, 32'h5); end
        checks++; if (B !== 32'h3) begin errors++; $display("FAIL load_B got %h want %h", B, 32'h3); end
        checks++; if (ALUFun !== 6'b011000) begin errors++; $display("FAIL load_ALUFun got %b want %b", ALUFun, 6'b011000); end
        checks++; if ({ex_valid, ex_RegWrite, ex_MemRead, ex_rd} !== {1'b1, 1'b1, 1'b0, 5'd8}) begin errors++; $display("FAIL load_ctrl got %b want %b", {ex_valid, ex_RegWrite, ex_MemRead, ex_rd}, {1'b1, 1'b1, 1'b0, 5'd8}); end
        id_ALUFun = ALU_OR;
        step();
        checks++; if (ALUFun !== 6'b011110) begin errors++; $display("FAIL load_or_ALUFun got %b want %b", ALUFun, 6'b011110); end
        checks++; if (A !== 32'h5 || B !== 32'h3) begin errors++; $display("FAIL load_or_AB got A=%h B=%h want 5/3", A, B); end
    endtask

    // Combinational checks only; stage keeps rs=3 (0x5), rt=4 (0x3) from test_load.
    task automatic test_forward();
        exmem_RegWrite = 1; exmem_rd = 3; exmem_result = 32'h1111_1111;
        memwb_RegWrite = 1; memwb_rd = 3; memwb_result = 32'h2222_2222;
        #1;
        checks++; if (A !== 32'h1111_1111) begin errors++; $display("FAIL fwd_exmem_wins got %h want %h", A, 32'h1111_1111); end
        checks++; if (B !== 32'h3) begin errors++; $display("FAIL fwd_rt_untouched got %h want %h", B, 32'h3); end
        exmem_RegWrite = 0;
        #1;
        checks++; if (A !== 32'h2222_2222) begin errors++; $display("FAIL fwd_memwb got %h want %h", A, 32'h2222_2222); end
        exmem_RegWrite = 1; exmem_rd = 0; memwb_rd = 0;
        #1;
        checks++; if (A !== 32'h5) begin errors++; $display("FAIL fwd_r0_none got %h want %h", A, 32'h5); end
        memwb_rd = 4;
        #1;
        checks++; if (B !== 32'h2222_2222 || ex_store_data !== 32'h2222_2222) begin errors++; $display("FAIL fwd_rt_memwb got B=%h st=%h want %h", B, ex_store_data, 32'h2222_2222); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_rd_dst = 7; id_rs_addr = 1; id_rt_addr = 2;
        step();
        id_rs_addr = 7; id_rt_addr = 2;
        #1;
        checks++; if (load_use_hazard !== 1'b1) begin errors++; $display("FAIL lu_rs got %b want 1", load_use_hazard); end
        id_rs_addr = 0; id_rt_addr = 7;
        #1;
        checks++; if (load_use_hazard !== 1'b1) begin errors++; $display("FAIL lu_rt got %b want 1", load_use_hazard); end
        id_rs_addr = 0; id_rt_addr = 0;
        #1;
        checks++; if (load_use_hazard !== 1'b0) begin errors++; $display("FAIL lu_nomatch got %b want 0", load_use_hazard); end
        // Load to r0 never raises the flag.
        id_rd_dst = 0;
        step();
        checks++; if (load_use_hazard !== 1'b0) begin errors++; $display("FAIL lu_rd0 got %b want 0", load_use_hazard); end
        // Invalid instruction never raises the flag.
        id_valid = 0; id_rd_dst = 7; id_rs_addr = 7;
        step();
        checks++; if (load_use_hazard !== 1'b0) begin errors++; $display("FAIL lu_invalid got %b want 0", load_use_hazard); end
        clear_inputs();
    endtask

    task automatic test_stall();
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rd_dst = 9; id_RegWrite = 1;
        id_rs_data = 32'h10; id_rt_data = 32'h20; id_ALUFun = ALU_ADD;
        step();
        // Stall cycle 1: MEM/WB forwards to rt; ID presents a different instruction.
        stall = 1;
        memwb_RegWrite = 1; memwb_rd = 2; memwb_result = 32'hDEAD_BEEF;
        id_rt_data = 32'h99; id_ALUFun = ALU_SUB; id_rd_dst = 12;
        #1;
        checks++; if (B !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_c1_B got %h want %h", B, 32'hDEAD_BEEF); end
        step();
        // Stall cycle 2: producer has retired.
        memwb_RegWrite = 0; memwb_result = 32'h0;
        #1;
        checks++; if (B !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_c2_B got %h want %h", B, 32'hDEAD_BEEF); end
        checks++; if (ALUFun !== ALU_ADD || ex_rd !== 5'd9) begin errors++; $display("FAIL stall_hold got fun=%b rd=%0d want %b/9", ALUFun, ex_rd, ALU_ADD); end
        step();
        stall = 0;
        #1;
        checks++; if (B !== 32'hDEAD_BEEF || A !== 32'h10) begin errors++; $display("FAIL stall_release got B=%h A=%h want deadbeef/10", B, A); end
        step();
        checks++; if (B !== 32'h99 || ALUFun !== ALU_SUB) begin errors++; $display("FAIL stall_next_load got B=%h fun=%b want 99/%b", B, ALUFun, ALU_SUB); end
        clear_inputs();
    endtask

    task automatic test_flush_stall();
        id_valid = 1; id_RegWrite = 1; id_rs_addr = 3; id_rs_data = 32'h42; id_ALUFun = ALU_XOR;
        step();
        stall = 1; flush = 1;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0) begin errors++; $display("FAIL flush_ctrl got v=%b rw=%b want 0/0", ex_valid, ex_RegWrite); end
        checks++; if (A !== 32'h0 || ALUFun !== 6'b0) begin errors++; $display("FAIL flush_data got A=%h fun=%b want 0", A, ALUFun); end
        stall = 0; flush = 0;
        clear_inputs();
    endtask

    task automatic test_imm_store();
        id_valid = 1; id_MemWrite = 1; id_rs_addr = 4; id_rt_addr = 4;
        id_rt_data = 32'h0; id_rs_data = 32'h0;
        id_ALUSrc2 = 1; id_imm = 32'hFFFF_8000;
        id_ALUSrc1 = 1; id_shamt = 5'h1F; id_ALUFun = ALU_SLL;
        step();
        exmem_RegWrite = 1; exmem_rd = 4; exmem_result = 32'h1234;
        #1;
        checks++; if (B !== 32'hFFFF_8000) begin errors++; $display("FAIL imm_B got %h want %h", B, 32'hFFFF_8000); end
        checks++; if (ex_store_data !== 32'h1234) begin errors++; $display("FAIL store_data got %h want %h", ex_store_data, 32'h1234); end
        checks++; if (A !== 32'h0000_001F) begin errors++; $display("FAIL shamt_A got %h want %h", A, 32'h1F); end
        checks++; if (ex_MemWrite !== 1'b1) begin errors++; $display("FAIL store_ctrl got %b want 1", ex_MemWrite); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        id_valid = 1; id_RegWrite = 1; id_rd_dst = 6;
        step();
        stall = 1; reset = 1;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin errors++; $display("FAIL reset_stall got v=%b rd=%0d want 0/0", ex_valid, ex_rd); end
        stall = 0; reset = 0;
        clear_inputs();
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        clear_inputs();
        step();
        step();
        test_reset();
        test_load();
        test_forward();
        test_load_use();
        test_stall();
        test_flush_stall();
        test_imm_store();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
